// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
//   Shared definitions for the instruction fetch stage and the IF/ID register:
//   - state_e      : fetch FSM state encoding (2 bits)
//   - RESET_PC     : first fetch address after reset
//   - NOP_INST     : canonical NOP (addi x0,x0,0) loaded by IF/ID on clear
//   - select_word  : picks the 32-bit instruction out of a 64-bit beat
// -----------------------------------------------------------------------------
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_e;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // The bus returns an aligned doubleword; address bit 2 chooses the half.
  function automatic logic [31:0] select_word(input logic [63:0] data,
                                              input logic        upper);
    return upper ? data[63:32] : data[31:0];
  endfunction

endpackage : if_stage_pkg

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   issues one read at a time on a valid/ready request channel, accepts a
//   single-beat response (no backpressure) and presents {pc, inst, valid}.
//   Honours downstream stall and EX redirect; responses belonging to a fetch
//   that was squashed by a redirect are discarded.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   stall_i           downstream hold; presented instruction stays stable
//   redirect_i        redirect request from EX (priority over stall/response)
//   redirect_pc_i     redirect target, bits [1:0] forced to zero
//   if_req_valid_o    fetch request valid
//   if_req_ready_i    bus accepts request
//   if_req_addr_o     8-byte aligned fetch address
//   if_resp_valid_i   response beat valid
//   if_resp_data_i    response data (64-bit doubleword)
//   pc_o, inst_o      PC and instruction being presented
//   inst_valid_o      pc_o/inst_o valid for the IF/ID register
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_stage_pkg::RESET_PC),
  parameter int unsigned     RDATA_W  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               if_req_valid_o,
  input  logic               if_req_ready_i,
  output logic [XLEN-1:0]    if_req_addr_o,
  input  logic               if_resp_valid_i,
  input  logic [RDATA_W-1:0] if_resp_data_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [31:0]        inst_o,
  output logic               inst_valid_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     inst_q, inst_d;
  // Set when the in-flight fetch was squashed; its response must be dropped.
  logic            drop_q, drop_d;

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;
  logic            handshake;

  assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign pc_inc       = pc_q + XLEN'(4);
  assign handshake    = (state_q == S_REQ) && if_req_ready_i;

  // Low address bits never influence a fetch: the target is word aligned and
  // the bus address is doubleword aligned.
  logic unused_bits;
  assign unused_bits = ^{redirect_pc_i[1:0], req_addr_q[1:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      inst_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      drop_q     <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    drop_d     = drop_q;

    unique case (state_q)
      S_IDLE: begin
        // Redirects are not honoured before the first request exists.
        state_d    = S_REQ;
        req_addr_d = pc_q;
      end

      S_REQ: begin
        // The request address is never changed while valid is high; a
        // redirect only retargets the PC and marks this fetch as stale.
        if (redirect_i) begin
          pc_d   = redirect_tgt;
          drop_d = 1'b1;
        end
        if (handshake) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_i) begin
          pc_d = redirect_tgt;
          if (if_resp_valid_i) begin
            // The response retires the squashed fetch in the same cycle, so
            // the new target can be requested right away.
            state_d    = S_REQ;
            req_addr_d = redirect_tgt;
            drop_d     = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end else if (if_resp_valid_i) begin
          if (drop_q) begin
            // pc_q already holds the latest redirect target.
            state_d    = S_REQ;
            req_addr_d = pc_q;
            drop_d     = 1'b0;
          end else begin
            state_d = S_OUT;
            inst_d  = select_word(if_resp_data_i[63:0], req_addr_q[2]);
          end
        end
      end

      S_OUT: begin
        if (redirect_i) begin
          state_d    = S_REQ;
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
        end else if (!stall_i) begin
          state_d    = S_REQ;
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Address and presented values are zeroed outside their states so that all
  // outputs read 0 in reset even though pc_q/req_addr_q reset to RESET_PC.
  always_comb begin
    if_req_valid_o = 1'b0;
    if_req_addr_o  = '0;
    inst_valid_o   = 1'b0;
    pc_o           = '0;
    inst_o         = '0;

    unique case (state_q)
      S_REQ: begin
        if_req_valid_o = 1'b1;
        if_req_addr_o  = {req_addr_q[XLEN-1:3], 3'b000};
      end
      S_OUT: begin
        inst_valid_o = 1'b1;
        pc_o         = pc_q;
        inst_o       = inst_q;
      end
      default: begin
      end
    endcase
  end

endmodule : if_stage

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC, issues one instruction read at a time on a valid/ready request channel, and accepts a single-beat response. It presents {pc, inst, valid} to the IF/ID register. It honours downstream stall and EX-stage redirect, and discards responses for squashed fetches.

Parameters:
XLEN, 64, PC and bus address width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
RDATA_W, 64, response data width; a 32-bit instruction is selected by addr[2]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall_i  in  1  downstream hold; present instruction must stay stable
redirect_i  in  1  branch/jump/trap redirect from EX
redirect_pc_i  in  XLEN  redirect target; bits [1:0] ignored and forced to 0
if_req_valid_o  out  1  fetch request valid
if_req_ready_i  in  1  bus accepts request
if_req_addr_o  out  XLEN  fetch address, 8-byte aligned, from req_addr_q with bits [2:0] zeroed
if_resp_valid_i  in  1  response beat valid; always accepted, no backpressure
if_resp_data_i  in  RDATA_W  response data
pc_o  out  XLEN  PC of presented instruction
inst_o  out  32  presented instruction
inst_valid_o  out  1  pc_o/inst_o valid for the IF/ID register

Behaviour:
- Reset is synchronous and active-low on clk (rst_n). Reset values: state=S_IDLE, pc_q=RESET_PC, req_addr_q=RESET_PC, drop_q=0, inst_q=0. All outputs are 0.
- Registers: pc_q (architectural fetch PC), req_addr_q (address of the in-flight request), inst_q, drop_q.
- States: S_IDLE, S_REQ, S_WAIT, S_OUT. The state is held in a register; all outputs are decoded from state and register contents.
- S_IDLE: next cycle go to S_REQ with req_addr_q=pc_q.
- S_REQ:
  - if_req_valid_o=1.
  - if_req_addr_o stays stable until if_req_ready_i. A request is never withdrawn.
  - On handshake, go to S_WAIT.
- S_WAIT:
  - On if_resp_valid_i with drop_q=0: inst_q = word selected by req_addr_q[2] (1 → data[63:32], 0 → data[31:0]), then go to S_OUT.
  - On if_resp_valid_i with drop_q=1: discard the data, clear drop_q, set req_addr_q=pc_q, go to S_REQ.
- S_OUT:
  - inst_valid_o=1, pc_o=pc_q, inst_o=inst_q.
  - If stall_i=1, stay in S_OUT with all outputs unchanged.
  - If stall_i=0, set pc_q=pc_q+4 (XLEN-bit wrap), req_addr_q=pc_q+4, go to S_REQ.
- Redirect (any state except S_IDLE); redirect has priority over stall_i and over a same-cycle response:
  - pc_q=redirect_pc_i with bits [1:0]=0.
  - In S_REQ without handshake: the request keeps its old address. Set drop_q=1.
  - In S_REQ with handshake: go to S_WAIT with drop_q=1.
  - In S_WAIT: if if_resp_valid_i is set the same cycle, discard the response and go to S_REQ with the target address. Otherwise set drop_q=1.
  - In S_OUT: go to S_REQ with req_addr_q=target. inst_valid_o is 0 in the next cycle.
- A redirect during an already-dropped fetch overwrites pc_q only, so the last target wins.
- Only one request is outstanding at a time. Zero-wait throughput is 1 instruction per 3 cycles (REQ, WAIT, OUT).
- if_resp_valid_i seen in S_IDLE, S_REQ or S_OUT is ignored.
- Reset asserted mid-transaction returns the block to the reset values on the next edge, regardless of state.

Decomposition:
- Shared package/defines holds:
  - the state encoding constants (S_IDLE/S_REQ/S_WAIT/S_OUT, 2 bits);
  - RESET_PC;
  - the 32'h0000_0013 NOP constant, used by the IF/ID register on clear.
- No sub-module is needed. Word selection is a single mux inside this block.

Test Plan:
- Release reset, ready=1, resp one cycle after accept with data 64'h0000_0013_0000_0093 → first req addr 0x8000_0000; pc_o=0x8000_0000, inst_o=0x0000_0093, inst_valid_o=1 two cycles after the handshake; next req addr 0x8000_0000 (pc 0x8000_0004 selects the upper word 0x0000_0013).
- stall_i=1 for 5 cycles while in S_OUT → pc_o/inst_o/inst_valid_o constant for all 5 cycles; no request issued; after release, req addr = next PC.
- redirect_i with target 0x8000_0100 in S_WAIT, response arrives 3 cycles later → the response is dropped, inst_valid_o stays 0, then a request to 0x8000_0100 is issued and its instruction is presented with pc_o=0x8000_0100.
- ready=0 for 4 cycles, redirect to 0x8000_0200 in cycle 2 → if_req_addr_o stays at the old address until accepted; its response is dropped; the next request goes to 0x8000_0200.
- redirect_i and stall_i both 1 in S_OUT → inst_valid_o=0 next cycle; next request goes to the target.
- redirect target 0x8000_0203 → pc_o=0x8000_0200.
- rst_n=0 for one cycle during S_WAIT, then a stale response arrives in S_IDLE → the response is ignored; a fresh request to 0x8000_0000 is issued.
